// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK check.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up to twice before reporting error.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_TICKS = 128,
  parameter int TIMEOUT_TICKS = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int IW = $clog2(INHIBIT_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IW-1:0] INH_START = IW'(INHIBIT_TICKS - 2);
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_SEND, S_WAITIDLE, S_FAIL} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_clk_shift;
  logic          r_filt, r_ps2d;
  logic [8:0]    r_frame, w_frame_nxt;
  logic [IW-1:0] r_inh_cnt, w_inh_nxt;
  logic [TW-1:0] r_to_cnt, w_to_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic          r_c_oe, w_c_oe_nxt, r_d_oe, w_d_oe_nxt;
  logic          r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
  logic          w_fall, w_fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    r_attempt, w_attempt_nxt;
`endif

  // Fall is the tick on which the filtered clock drops from 1 to 0.
  assign w_fall = r_filt & (r_clk_shift == 8'h00);

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_inh_nxt   = r_inh_cnt;
    w_to_nxt    = r_to_cnt;
    w_bit_nxt   = r_bit;
    w_c_oe_nxt  = r_c_oe;
    w_d_oe_nxt  = r_d_oe;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_attempt_nxt = r_attempt;
`endif
    case (r_state)
      S_IDLE: begin
        w_c_oe_nxt = 1'b0;
        w_d_oe_nxt = 1'b0;
        if (valid) begin
          w_frame_nxt = {~^data, data};
          w_busy_nxt  = 1'b1;
          w_c_oe_nxt  = 1'b1;
          w_inh_nxt   = '0;
          w_state_nxt = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_attempt_nxt = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        w_inh_nxt = r_inh_cnt + 1'b1;
        if (r_inh_cnt == INH_START) w_d_oe_nxt = 1'b1;
        if (r_inh_cnt == INH_LAST) begin
          w_c_oe_nxt  = 1'b0;
          w_bit_nxt   = 4'd0;
          w_to_nxt    = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_fall) begin
          w_to_nxt  = '0;
          w_bit_nxt = r_bit + 1'b1;
          if (r_bit <= 4'd8)       w_d_oe_nxt = ~r_frame[r_bit];
          else if (r_bit == 4'd9)  w_d_oe_nxt = 1'b0;
          else if (r_ps2d)         w_fail = 1'b1;
          else                     w_state_nxt = S_WAITIDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_WAITIDLE: begin
        if (r_filt && r_ps2d) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_FAIL: begin
        w_c_oe_nxt  = 1'b0;
        w_d_oe_nxt  = 1'b0;
        w_err_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fail) begin
      w_c_oe_nxt  = 1'b0;
      w_d_oe_nxt  = 1'b0;
      w_state_nxt = S_FAIL;
`ifdef PS2_TX_RETRY_EN
      if (r_attempt != 2'd2) begin
        w_attempt_nxt = r_attempt + 2'd1;
        w_c_oe_nxt    = 1'b1;
        w_inh_nxt     = '0;
        w_state_nxt   = S_INHIBIT;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clk_shift <= 8'hFF;
      r_filt      <= 1'b1;
      r_ps2d      <= 1'b1;
      r_frame     <= '0;
      r_inh_cnt   <= '0;
      r_to_cnt    <= '0;
      r_bit       <= '0;
      r_c_oe      <= 1'b0;
      r_d_oe      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      r_attempt   <= '0;
`endif
    end else if (ce) begin
      r_clk_shift <= {r_clk_shift[6:0], ps2[0]};
      if (r_clk_shift == 8'hFF)      r_filt <= 1'b1;
      else if (r_clk_shift == 8'h00) r_filt <= 1'b0;
      r_ps2d    <= ps2[1];
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_inh_cnt <= w_inh_nxt;
      r_to_cnt  <= w_to_nxt;
      r_bit     <= w_bit_nxt;
      r_c_oe    <= w_c_oe_nxt;
      r_d_oe    <= w_d_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
`ifdef PS2_TX_RETRY_EN
      r_attempt <= w_attempt_nxt;
`endif
    end
  end

  assign ps2c_oe = r_c_oe;
  assign ps2d_oe = r_d_oe;
  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_err;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model driving the PS/2 clock.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  logic       clock = 1'b0, reset = 1'b1, ce = 1'b0;
  logic [1:0] ps2;
  logic       ps2c_oe, ps2d_oe, busy, done, error;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  int pass_cnt = 0, total = 0;
  int done_cnt = 0, err_cnt = 0, inh_ticks = 0, inh_phases = 0, start_ticks = 0, both_cnt = 0;
  logic prev_c = 1'b0;
  logic [10:1] obs;

  always #5 clock = ~clock;
  always @(negedge clock) ce = ~ce;

  assign ps2 = {dev_dat & ~ps2d_oe, dev_clk & ~ps2c_oe};

  ps2_host_tx dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .data(data), .valid(valid),
    .busy(busy), .done(done), .error(error)
  );

  task automatic tick();
    @(posedge clock);
    while (ce !== 1'b1) @(posedge clock);
    #1;
  endtask

  always begin
    tick();
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (ps2c_oe) inh_ticks++;
    if (ps2c_oe && ps2d_oe) start_ticks++;
    if (ps2c_oe && !prev_c) inh_phases++;
    prev_c = ps2c_oe;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total);
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    data = b; valid = 1'b1; tick(); valid = 1'b0;
  endtask

  // Keyboard model: waits for the start bit, then clocks nfalls falling edges.
  task automatic dev_frame(input int nfalls, input bit ack, input bit glitch);
    int t = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && t < 5000) begin tick(); t++; end
    if (t >= 5000) begin total++; $display("FAIL release_wait: no start bit after %0d ticks", t); end
    repeat (12) tick();
    for (int k = 1; k <= nfalls; k++) begin
      if (glitch) begin
        dev_clk = 1'b0; repeat ((k % 3) + 1) tick();
        dev_clk = 1'b1; repeat (12) tick();
      end
      if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0; repeat (12) tick();
      if (k <= 10) obs[k] = ps2d_oe;
      dev_clk = 1'b1; repeat (12) tick();
    end
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({ps2c_oe, ps2d_oe, busy, done, error} !== 5'b0)
      $display("FAIL reset_hold: outputs %b required 00000", {ps2c_oe, ps2d_oe, busy, done, error});
    else pass_cnt++;
    reset = 1'b0;
    repeat (5) tick();
    total++;
    if ({ps2c_oe, ps2d_oe, busy, done, error} !== 5'b0)
      $display("FAIL reset_idle: outputs %b required 00000", {ps2c_oe, ps2d_oe, busy, done, error});
    else pass_cnt++;
  endtask

  task automatic test_ack_frame(input logic [7:0] b, input logic [10:1] exp_d);
    int d0, e0, i0, s0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_ticks; s0 = start_ticks;
    obs = '0;
    send(b);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_set %h: got %b required 1", b, busy); else pass_cnt++;
    dev_frame(11, 1'b1, 1'b0);
    repeat (6) tick();
    total++;
    if (obs !== exp_d) $display("FAIL bits %h: d_oe per fall %b required %b", b, obs, exp_d); else pass_cnt++;
    total++;
    if (inh_ticks - i0 !== 128) $display("FAIL inhibit_len %h: got %0d required 128", b, inh_ticks - i0); else pass_cnt++;
    total++;
    if (start_ticks - s0 !== 1) $display("FAIL start_overlap %h: got %0d required 1", b, start_ticks - s0); else pass_cnt++;
    total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
      $display("FAIL done_pulse %h: done %0d error %0d required 1 and 0", b, done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    total++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000)
      $display("FAIL end_idle %h: busy/c/d %b required 000", b, {busy, ps2c_oe, ps2d_oe});
    else pass_cnt++;
  endtask

  task automatic test_nack();
    int d0, e0, p0, attempts;
    d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
`ifdef PS2_TX_RETRY_EN
    attempts = 3;
`else
    attempts = 1;
`endif
    send(8'h55);
    for (int a = 0; a < attempts; a++) dev_frame(11, 1'b0, 1'b0);
    repeat (4) tick();
    total++;
    if (inh_phases - p0 !== attempts)
      $display("FAIL nack_phases: got %0d required %0d", inh_phases - p0, attempts);
    else pass_cnt++;
    total++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
      $display("FAIL nack_error: error %0d done %0d required 1 and 0", err_cnt - e0, done_cnt - d0);
    else pass_cnt++;
    total++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000)
      $display("FAIL nack_release: busy/c/d %b required 000", {busy, ps2c_oe, ps2d_oe});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int d0, e0, t, attempts;
    d0 = done_cnt; e0 = err_cnt; t = 0;
`ifdef PS2_TX_RETRY_EN
    attempts = 3;
`else
    attempts = 1;
`endif
    send(8'h3C);
    for (int a = 0; a < attempts; a++) dev_frame(4, 1'b1, 1'b0);
    while (err_cnt == e0 && t < 3000) begin tick(); t++; end
    // Fall 4 lands 15 ticks before dev_frame returns; the error pulse follows ~2048 ticks after it.
    total++;
    if (t < 2020 || t > 2050) $display("FAIL timeout_delay: got %0d ticks required 2020..2050", t); else pass_cnt++;
    total++;
    if (done_cnt - d0 !== 0) $display("FAIL timeout_done: got %0d required 0", done_cnt - d0); else pass_cnt++;
    tick();
    total++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000)
      $display("FAIL timeout_release: busy/c/d %b required 000", {busy, ps2c_oe, ps2d_oe});
    else pass_cnt++;
    test_ack_frame(8'hF4, 10'h10B);
  endtask

  task automatic test_busy_ignore();
    int d0, p0;
    d0 = done_cnt; p0 = inh_phases;
    obs = '0;
    send(8'hA5);
    repeat (3) begin data = 8'h3C; valid = 1'b1; tick(); end
    valid = 1'b0;
    dev_frame(11, 1'b1, 1'b0);
    repeat (6) tick();
    total++;
    if (obs !== 10'h05A) $display("FAIL busy_ignore_bits: got %b required %b", obs, 10'h05A); else pass_cnt++;
    total++;
    if (inh_phases - p0 !== 1 || done_cnt - d0 !== 1)
      $display("FAIL busy_ignore_count: phases %0d done %0d required 1 and 1", inh_phases - p0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_send();
    int d0, e0;
    send(8'h00);
    dev_frame(5, 1'b1, 1'b0);
    dev_clk = 1'b0; repeat (12) tick();
    total++;
    if (ps2d_oe !== 1'b1) $display("FAIL fall6_drive: d_oe %b required 1", ps2d_oe); else pass_cnt++;
    #3 reset = 1'b1;
    #1;
    total++;
    if ({busy, ps2c_oe, ps2d_oe} !== 3'b000)
      $display("FAIL async_reset: busy/c/d %b required 000", {busy, ps2c_oe, ps2d_oe});
    else pass_cnt++;
    d0 = done_cnt; e0 = err_cnt;
    dev_clk = 1'b1; repeat (4) tick();
    reset = 1'b0; repeat (30) tick();
    total++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || busy !== 1'b0)
      $display("FAIL reset_quiet: done %0d error %0d busy %b required 0 0 0", done_cnt - d0, err_cnt - e0, busy);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int d0;
    d0 = done_cnt;
    obs = '0;
    send(8'hED);
    dev_frame(11, 1'b1, 1'b1);
    repeat (6) tick();
    total++;
    if (obs !== 10'h012) $display("FAIL glitch_bits: got %b required %b", obs, 10'h012); else pass_cnt++;
    total++;
    if (done_cnt - d0 !== 1) $display("FAIL glitch_done: got %0d required 1", done_cnt - d0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ack_frame(8'hED, 10'h012);
    test_ack_frame(8'hFF, 10'h000);
    test_ack_frame(8'h00, 10'h0FF);
    test_nack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_send();
    test_glitch();
    total++;
    if (both_cnt !== 0) $display("FAIL done_and_error: %0d overlapping ticks required 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
